// File: rtl/dma_guard_multi.sv
// Purpose : secure-region / key-region access guard for N_DMA DMA masters and the CPU PC; requests MCU reset on violation.
// Latency : violation detected combinationally, reset/cause/chan/count registered one cycle after the violating cycle.
// Backpr. : none; inputs are sampled every cycle, KILL is held for HOLD_CYCLES and then until pc reaches RESET_HANDLER.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   pc                current CPU program counter
//   dma_addr, dma_en  per-channel DMA address (16 bits each, channel i at [16*i+15:16*i]) and strobe
//   irq               interrupt indication
//   reset             1 = hold the MCU in reset (state is KILL)
//   viol_cause        {key_dma, smem_dma, smem_irq} latched at the last RUN->KILL transition
//   viol_chan         lowest DMA channel involved in the last violation
//   viol_count        saturating count of RUN->KILL transitions
module dma_guard_multi #(
  parameter logic [15:0] SMEM_BASE     = 16'hE000,
  parameter logic [15:0] SMEM_SIZE     = 16'h1000,
  parameter logic [15:0] KEY_BASE      = 16'h6A00,
  parameter logic [15:0] KEY_SIZE      = 16'h0040,
  parameter int          N_DMA         = 2,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter logic [7:0]  HOLD_CYCLES   = 8'd4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          pc,
  input  logic [16*N_DMA-1:0]  dma_addr,
  input  logic [N_DMA-1:0]     dma_en,
  input  logic                 irq,
  output logic                 reset,
  output logic [2:0]           viol_cause,
  output logic [2:0]           viol_chan,
  output logic [7:0]           viol_count
);

  // Region bounds, inclusive on both ends; last instruction is word-aligned.
  localparam logic [15:0] LAST_SMEM = SMEM_BASE + SMEM_SIZE - 16'd2;
  localparam logic [15:0] KEY_LAST  = KEY_BASE + KEY_SIZE - 16'd1;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic        reset_q, reset_d;
  logic [2:0]  cause_q, cause_d;
  logic [2:0]  chan_q, chan_d;
  logic [7:0]  count_q, count_d;

  logic             in_smem;
  logic [N_DMA-1:0] key_hit;
  logic             smem_dma, smem_irq, key_dma, viol;
  logic [2:0]       en_chan, key_chan, viol_chan_c;

  // Violation detection.
  always_comb begin
    in_smem = (pc >= SMEM_BASE) && (pc <= LAST_SMEM);
    key_hit = '0;
    for (int i = 0; i < N_DMA; i++) begin
      key_hit[i] = dma_en[i] && (dma_addr[16*i +: 16] >= KEY_BASE)
                             && (dma_addr[16*i +: 16] <= KEY_LAST);
    end
    smem_dma = in_smem && (|dma_en);
    smem_irq = in_smem && irq;
    key_dma  = |key_hit;
    viol     = smem_dma || smem_irq || key_dma;
  end

  // Lowest-index channel: scan downward so the lowest set bit wins.
  always_comb begin
    en_chan  = 3'd0;
    key_chan = 3'd0;
    for (int i = N_DMA - 1; i >= 0; i--) begin
      if (dma_en[i])  en_chan  = 3'(i);
      if (key_hit[i]) key_chan = 3'(i);
    end
    if (smem_dma)     viol_chan_c = en_chan;
    else if (key_dma) viol_chan_c = key_chan;
    else              viol_chan_c = 3'd0;
  end

  // Next-state logic. Logs and counter only move on RUN->KILL.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    cause_d = cause_q;
    chan_d  = chan_q;
    count_d = count_q;
    unique case (state_q)
      RUN: begin
        if (viol) begin
          state_d = KILL;
          hcnt_d  = HOLD_CYCLES - 8'd1;
          cause_d = {key_dma, smem_dma, smem_irq};
          chan_d  = viol_chan_c;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
      end
      KILL: begin
        if (hcnt_q != 8'd0) begin
          hcnt_d = hcnt_q - 8'd1;
        end else if ((pc == RESET_HANDLER) && !viol) begin
          state_d = RUN;
        end
      end
      default: state_d = KILL;
    endcase
    reset_d = (state_d == KILL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= KILL;
      hcnt_q  <= 8'd0;
      reset_q <= 1'b1;
      cause_q <= 3'd0;
      chan_q  <= 3'd0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      reset_q <= reset_d;
      cause_q <= cause_d;
      chan_q  <= chan_d;
      count_q <= count_d;
    end
  end

  assign reset      = reset_q;
  assign viol_cause = cause_q;
  assign viol_chan  = chan_q;
  assign viol_count = count_q;

endmodule

// File: tb/tb_dma_guard_multi.sv
// Purpose : directed self-checking bench for dma_guard_multi with default parameters.
// Latency : outputs sampled 1 ns after each rising edge, inputs driven at the same point.
// Backpr. : none.
module tb_dma_guard_multi;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [31:0] dma_addr;
  logic [1:0]  dma_en;
  logic        irq;
  logic        reset;
  logic [2:0]  viol_cause;
  logic [2:0]  viol_chan;
  logic [7:0]  viol_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  dma_guard_multi dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .dma_addr   (dma_addr),
    .dma_en     (dma_en),
    .irq        (irq),
    .reset      (reset),
    .viol_cause (viol_cause),
    .viol_chan  (viol_chan),
    .viol_count (viol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rst, input logic [2:0] cause,
                           input logic [2:0] chan, input logic [7:0] cnt);
    check({tag, ".reset"}, 16'(reset), 16'(rst));
    check({tag, ".cause"}, 16'(viol_cause), 16'(cause));
    check({tag, ".chan"},  16'(viol_chan), 16'(chan));
    check({tag, ".count"}, 16'(viol_count), 16'(cnt));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    pc = 16'h0000; dma_en = 2'b00; dma_addr = 32'h0; irq = 1'b0;
  endtask

  // Hold of 4 cycles: reset seen high after the violating edge and 3 more, then low.
  task automatic recover(input string tag);
    idle();
    repeat (3) begin
      tick();
      check({tag, ".hold"}, 16'(reset), 16'd1);
    end
    tick();
    check({tag, ".exit"}, 16'(reset), 16'd0);
  endtask

  task automatic quick_viol;
    pc = 16'hE100; irq = 1'b1;
    tick();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset held low for two cycles.
    tick();
    check_all("rst0", 1'b1, 3'b000, 3'd0, 8'd0);
    tick();
    check_all("rst1", 1'b1, 3'b000, 3'd0, 8'd0);
    rst_n = 1'b1;
    tick();
    check_all("rel", 1'b0, 3'b000, 3'd0, 8'd0);

    // Secure-region DMA on channel 1, with a second violation mid-hold.
    pc = 16'hE100; dma_en = 2'b10;
    tick(); exp_cnt++;
    check_all("smem_dma", 1'b1, 3'b010, 3'd1, 8'(exp_cnt));
    idle();
    tick();
    check("hold1", 16'(reset), 16'd1);
    pc = 16'hE100; irq = 1'b1;
    tick();
    check_all("hold_viol", 1'b1, 3'b010, 3'd1, 8'(exp_cnt));
    idle();
    tick();
    check("hold3", 16'(reset), 16'd1);
    tick();
    check("hold_exit", 16'(reset), 16'd0);

    // Key hit at last key byte on channel 0, pc outside secure region.
    pc = 16'h4000; dma_en = 2'b01; dma_addr = {16'h0000, 16'h6A3F};
    tick(); exp_cnt++;
    check_all("key_last", 1'b1, 3'b100, 3'd0, 8'(exp_cnt));
    recover("key_last");

    // One past the key region, and one below it: no violation.
    pc = 16'h4000; dma_en = 2'b01; dma_addr = {16'h0000, 16'h6A40};
    tick();
    check_all("key_past", 1'b0, 3'b100, 3'd0, 8'(exp_cnt));
    dma_addr = {16'h0000, 16'h69FF};
    tick();
    check("key_below", 16'(reset), 16'd0);

    // Key hit only on channel 1 while channel 0 is enabled elsewhere.
    dma_en = 2'b11; dma_addr = {16'h6A00, 16'h1234};
    tick(); exp_cnt++;
    check_all("key_ch1", 1'b1, 3'b100, 3'd1, 8'(exp_cnt));
    recover("key_ch1");

    // Last secure instruction with irq; channel log returns to 0.
    pc = 16'hEFFE; irq = 1'b1;
    tick(); exp_cnt++;
    check_all("irq_last", 1'b1, 3'b001, 3'd0, 8'(exp_cnt));
    recover("irq_last");

    // Outside bounds with irq: no violation.
    pc = 16'hF000; irq = 1'b1;
    tick();
    check("irq_f000", 16'(reset), 16'd0);
    pc = 16'hDFFE;
    tick();
    check("irq_dffe", 16'(reset), 16'd0);

    // First secure word with irq, DMA into secure code and key region at once.
    pc = 16'hE000; irq = 1'b1; dma_en = 2'b11; dma_addr = {16'h6A00, 16'h0000};
    tick(); exp_cnt++;
    check_all("all_causes", 1'b1, 3'b111, 3'd0, 8'(exp_cnt));
    recover("all_causes");

    // Stay in KILL while pc is not the reset handler.
    pc = 16'hE100; irq = 1'b1;
    tick(); exp_cnt++;
    idle(); pc = 16'h1000;
    repeat (6) tick();
    check("kill_wait", 16'(reset), 16'd1);
    pc = 16'h0000;
    tick();
    check("kill_leave", 16'(reset), 16'd0);

    // Saturation of the violation counter.
    repeat (260) quick_viol();
    check_all("sat", 1'b0, 3'b001, 3'd0, 8'hFF);

    // Reset mid-hold clears all logs.
    pc = 16'h4000; dma_en = 2'b01; dma_addr = {16'h0000, 16'h6A01};
    tick();
    idle();
    tick();
    rst_n = 1'b0;
    tick();
    check_all("mid_rst", 1'b1, 3'b000, 3'd0, 8'd0);
    rst_n = 1'b1;
    tick();
    check_all("mid_rel", 1'b0, 3'b000, 3'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
